wide_word_loader: RTL
=====================

# wide_word_loader

Word-serial assembler that feeds the 1024-bit zero detector. Accepts fixed-width chunks over a valid/ready handshake, packs them LSB-first into a WIDTH-bit register, and presents the completed word on `A` with `out_valid` until the consumer takes it. The zero detector's `A` input connects directly to this block's `A` output; downstream logic samples its result only while `out_valid` is high.

## Interface
- `WIDTH`, 1024, assembled word width; must be an integer multiple of CHUNK
- `CHUNK`, 32, input chunk width
- NCHUNK = WIDTH/CHUNK (derived, 32 by default); CW = $clog2(NCHUNK)+1 (derived, 6 by default)

- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `in_data` carries a chunk
- `in_ready`  out  1  block can accept a chunk this cycle
- `in_data`  in  CHUNK  chunk payload
- `abort`  in  1  discard the partially filled word
- `out_valid`  out  1  `A` holds a complete word
- `out_ready`  in  1  consumer takes the word this cycle
- `A`  out  WIDTH  assembled word, registered
- `fill_cnt`  out  CW  chunks accepted into the current word, 0..NCHUNK

## Operation
- States: FILL and HOLD. Reset state is FILL.
- Reset values: `A`=0, `fill_cnt`=0, `out_valid`=0. `in_ready`=0 in any cycle with `rst` high.
- `in_ready` = (state==FILL) && !abort && !rst. It is combinational from state and `abort` only. It never depends on `in_valid`.
- Accept = `in_valid` && `in_ready`.
- FILL, accept with `fill_cnt`==k:
  - The chunk is written to `A[k*CHUNK +: CHUNK]`.
  - If k==0, all other bits of `A` are cleared in the same edge. Stale bits from the previous word never survive.
  - `fill_cnt` becomes k+1.
- FILL, accept with k==NCHUNK-1: the next state is HOLD, `out_valid` becomes 1, and `fill_cnt` becomes NCHUNK.
- FILL, `abort` high: `fill_cnt` becomes 0, `A` becomes 0, no chunk is accepted, and the block stays in FILL. Abort takes priority over `in_valid`.
- FILL, no accept and no abort: all state holds.
- HOLD:
  - `A` is stable and `in_ready`=0. `abort` is ignored.
  - When `out_valid` && `out_ready`, the next state is FILL, `out_valid` becomes 0 and `fill_cnt` becomes 0. `A` keeps its value until the next first-chunk accept.
- Chunk order is LSB-first: chunk 0 maps to `A[CHUNK-1:0]` and chunk NCHUNK-1 maps to the MSBs.
- `A` is valid for consumers only while `out_valid`=1. During FILL, `A` shows the partial word.
- Counter wrap cannot happen: `fill_cnt` never exceeds NCHUNK.

## Timing
- Registered outputs: `A`, `out_valid`, `fill_cnt`.
- The final chunk is accepted at edge N. `out_valid`=1 and the full `A` are visible from the cycle after edge N.
- `out_valid` stays high until the handshake edge. In the cycle after the handshake, `in_ready`=1 again (absent `abort`/`rst`).
- Minimum period per word: NCHUNK+1 cycles, i.e. NCHUNK accept cycles plus one HOLD cycle with `out_ready` tied high. There is no bypass from HOLD to FILL within a cycle.
- Back-to-back accepts are sustained every cycle in FILL.
- `rst` mid-fill or in HOLD returns every register to its reset value at that edge. Any pending word is lost and no `out_valid` pulse is produced.
- Sequence: the downstream zero flag is combinational on `A` and is meaningful from the cycle `out_valid` rises.

## Test plan
- Basic fill: send 32 chunks with chunk k = 32'h0000_0100+k, `out_ready`=1 → `out_valid` rises the cycle after chunk 31. `A[31:0]`=32'h100 and `A[1023:992]`=32'h11F. It is high for exactly 1 cycle. `fill_cnt` reads 32, then 0.
- Zero word: 32 chunks of 0 → `A`=0 with `out_valid`=1 and the detector output Q=1. Next word with only chunk 17 = 32'h1 → `A[544]`=1 and Q=0. This proves clearing on chunk 0.
- Backpressure: `out_ready`=0 for 10 cycles after a fill → `out_valid`, `A` and `fill_cnt`=32 hold. `in_ready`=0 throughout and extra `in_valid` is ignored. Raising `out_ready` completes the transfer in 1 cycle.
- Abort: accept 5 chunks, then `abort`=1 together with `in_valid`=1 → `in_ready`=0 that cycle, then `fill_cnt`=0 and `A`=0. The next 32 chunks form a clean word.
- Reset mid-operation: `rst` for one cycle after chunk 20 and again during HOLD → `A`=0, `fill_cnt`=0, `out_valid`=0 the next cycle, and `in_ready`=0 while `rst`=1.
- Random valid/ready gaps (≈50% duty on both sides) over 100 words → each word matches the scoreboard, no lost or duplicated chunks, and `A` is stable whenever `out_valid`=1.

Source files
------------

// File: rtl/wide_word_loader.sv
// Word-serial assembler: packs CHUNK-wide chunks LSB-first into a WIDTH-bit word
// and holds the completed word on A with out_valid until the consumer takes it.
module wide_word_loader #(
   parameter  int WIDTH  = 1024,
   parameter  int CHUNK  = 32,
   localparam int NCHUNK = WIDTH / CHUNK,
   localparam int CW     = $clog2(NCHUNK) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CHUNK-1:0] in_data,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] A,
   output logic [CW-1:0]    fill_cnt
);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [CW-1:0]    fill_cnt_q, fill_cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             accept;

   assign in_ready = (state_q == FILL) && !abort && !rst;
   assign accept   = in_valid && in_ready;

   // NOTE: every signal written here gets its default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      fill_cnt_d  = fill_cnt_q;
      out_valid_d = out_valid_q;
      case (state_q)
         FILL: begin
            if (abort) begin
               a_d        = '0;
               fill_cnt_d = '0;
            end else if (accept) begin
               // First chunk of a new word wipes whatever the previous word left behind.
               if (fill_cnt_q == '0) a_d = '0;
               for (int i = 0; i < NCHUNK; i++) begin
                  if (fill_cnt_q == CW'(i)) a_d[i*CHUNK +: CHUNK] = in_data;
               end
               fill_cnt_d = fill_cnt_q + CW'(1);
               if (fill_cnt_q == CW'(NCHUNK - 1)) begin
                  state_d     = HOLD;
                  out_valid_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (out_valid_q && out_ready) begin
               state_d     = FILL;
               out_valid_d = 1'b0;
               fill_cnt_d  = '0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order. The wide A register
   // is reset too, because consumers and the zero detector must see 0 after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         a_q         <= '0;
         fill_cnt_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         fill_cnt_q  <= fill_cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign A         = a_q;
   assign fill_cnt  = fill_cnt_q;
   assign out_valid = out_valid_q;

endmodule
